ingr_upd_req_arb: RTL and testbench
===================================

# ingr_upd_req_arb

Four-input arbiter that merges the ingress rcv_nxt update request streams (connection-establish ports 0/1 and receive ports 0/1) into one 64-bit request stream for the ingress event core. Establish requests get strict priority over receive requests, with a starvation guard for the receive group. Each group is served round-robin internally. Accepted requests go through a 2-entry output buffer, so the block sustains one request per cycle. It also keeps per-source grant counters for debug readout.

## Interface
Parameters:
- DATA_WIDTH, 64, request payload width; passed through unmodified.
- STARVE_LIMIT, 8, maximum number of consecutive high-group grants while a low-group request is pending; range 1..255.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- req_0_tdata / req_0_tvalid / req_0_tready  in/in/out  DATA_WIDTH/1/1  establish port 0 (high group).
- req_1_tdata / req_1_tvalid / req_1_tready  in/in/out  DATA_WIDTH/1/1  establish port 1 (high group).
- req_2_tdata / req_2_tvalid / req_2_tready  in/in/out  DATA_WIDTH/1/1  receive port 0 (low group).
- req_3_tdata / req_3_tvalid / req_3_tready  in/in/out  DATA_WIDTH/1/1  receive port 1 (low group).
- upd_req_tdata  out  DATA_WIDTH  merged request payload.
- upd_req_tuser  out  2  source index (0..3) of the payload.
- upd_req_tvalid  out  1  merged request valid.
- upd_req_tready  in  1  downstream ready.
- cnt_clear  in  1  synchronous clear of all grant counters.
- grant_count_0..3  out  32 each  number of accepted requests per source; wraps at 2^32.

## Operation
- Input handshake occurs when req_N_tvalid & req_N_tready. At most one req_N_tready is high per cycle, and only for the granted port.
- accept = (buffer occupancy < 2), computed from registered state.
- req_N_tready = accept & grant[N].
  - grant is combinational from the tvalid inputs, the pointers and the starvation counter.
  - tready may depend on tvalid; tvalid never depends on tready.
- Group selection:
  - hi_pend = req_0_tvalid | req_1_tvalid.
  - lo_pend = req_2_tvalid | req_3_tvalid.
  - The low group wins if lo_pend & (!hi_pend | starve_cnt == STARVE_LIMIT).
  - Otherwise the high group wins if hi_pend.
  - Otherwise no grant is issued.
- Within-group round-robin:
  - One 1-bit pointer per group: rr_hi selects 0/1, rr_lo selects 2/3.
  - The pointed port is granted if valid, else the other port.
  - On a handshake the group pointer moves to the port after the granted one.
  - Pointers do not move without a handshake.
- Starvation counter starve_cnt (8 bits):
  - On a high-group handshake with lo_pend: increment, saturating at STARVE_LIMIT.
  - On a low-group handshake, or any cycle with !lo_pend: cleared to 0.
- Output buffer:
  - 2-entry FIFO of {tuser, tdata}.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - upd_req_tvalid = occupancy != 0.
  - Head entry data stays stable while tvalid & !tready.
- Grant counters:
  - grant_count_N increments on each handshake of port N.
  - cnt_clear has priority: when asserted, all counters go to 0 that cycle and that cycle's handshake is not counted.
  - Counters wrap 0xFFFFFFFF -> 0.

## Timing
- Reset values:
  - all req_N_tready 0 during reset;
  - upd_req_tvalid 0, upd_req_tdata 0, upd_req_tuser 0;
  - grant_count_N 0;
  - rr_hi and rr_lo point to port 0 / port 2;
  - starve_cnt 0;
  - occupancy 0.
- Reset asserted mid-transfer discards buffered entries; there is no partial output.
- Latency: an input handshake in cycle T gives upd_req_tvalid in T+1 when the buffer was empty.
- Throughput: one request per cycle while upd_req_tready is held high.
- Full buffer (occupancy 2): all tready are low. They return high the cycle after the first pop.
- grant_count_N reflects a handshake in cycle T from cycle T+1.
- Simultaneous valid on all four ports with the downstream always ready gives a steady-state grant sequence of STARVE_LIMIT high grants, then one low grant, repeating.

## Test plan
- Single source: req_2 sends 0x11, 0x22, 0x33 back-to-back with upd_req_tready=1.
  - Output is 0x11, 0x22, 0x33 on consecutive cycles, tuser=2, first output at T+1.
  - grant_count_2 = 3.
- High-group round-robin: req_0 and req_1 both continuously valid, low group idle.
  - Grants alternate 0,1,0,1 starting at 0.
  - starve_cnt stays 0.
- Starvation guard: all four continuously valid, STARVE_LIMIT=8.
  - Grants are 8 high-group grants alternating 0/1, then port 2.
  - The next 8 are high-group grants, then port 3.
  - Pattern repeats.
- Backpressure: upd_req_tready=0 while req_0 valid.
  - Exactly 2 handshakes, then all tready low.
  - Raise tready: output 2 entries in order with no loss or duplication, and tready returns the cycle after the first pop.
- Counter clear/wrap:
  - Preload via 0xFFFFFFFF handshakes (forced), next handshake gives 0.
  - cnt_clear in the same cycle as a handshake leaves the counter at 0.
- Reset mid-operation: ap_rst_n low for one cycle with occupancy 2.
  - Next cycle: upd_req_tvalid=0, counters 0, pointers at ports 0/2.

Source files
------------

// File: rtl/ingr_upd_req_arb.sv
// Merges four rcv_nxt update request streams into one, establish ports first,
// with a starvation guard for the receive ports and a 2-entry output buffer.
module ingr_upd_req_arb #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] req_0_tdata,
  input  logic                  req_0_tvalid,
  output logic                  req_0_tready,
  input  logic [DATA_WIDTH-1:0] req_1_tdata,
  input  logic                  req_1_tvalid,
  output logic                  req_1_tready,
  input  logic [DATA_WIDTH-1:0] req_2_tdata,
  input  logic                  req_2_tvalid,
  output logic                  req_2_tready,
  input  logic [DATA_WIDTH-1:0] req_3_tdata,
  input  logic                  req_3_tvalid,
  output logic                  req_3_tready,
  output logic [DATA_WIDTH-1:0] upd_req_tdata,
  output logic [1:0]            upd_req_tuser,
  output logic                  upd_req_tvalid,
  input  logic                  upd_req_tready,
  input  logic                  cnt_clear,
  output logic [31:0]           grant_count_0,
  output logic [31:0]           grant_count_1,
  output logic [31:0]           grant_count_2,
  output logic [31:0]           grant_count_3
);

  localparam int         EW  = DATA_WIDTH + 2;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [3:0]            vld;
  logic                  hi_pend;
  logic                  lo_pend;
  logic                  lo_win;
  logic                  gv;
  logic                  accept;
  logic                  hs;
  logic                  pop;
  logic [1:0]            hi_idx;
  logic [1:0]            lo_idx;
  logic [1:0]            gidx;
  logic [DATA_WIDTH-1:0] gdata;

  logic                  rr_hi_q;
  logic                  rr_lo_q;
  logic [7:0]            starve_q;
  logic [7:0]            starve_d;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  wp_q;
  logic                  rp_q;
  logic [1:0][EW-1:0]    mem_q;
  logic [3:0][31:0]      cnt_q;

  assign vld = {req_3_tvalid, req_2_tvalid,
                req_1_tvalid, req_0_tvalid};

  assign hi_pend = vld[0] | vld[1];
  assign lo_pend = vld[2] | vld[3];
  assign lo_win  = lo_pend & (!hi_pend | (starve_q == LIM));

  // Pointed port if valid, otherwise its sibling
  assign hi_idx = {1'b0, rr_hi_q ? vld[1] : ~vld[0]};
  assign lo_idx = {1'b1, rr_lo_q ? vld[3] : ~vld[2]};

  assign gv   = lo_win | hi_pend;
  assign gidx = lo_win ? lo_idx : hi_idx;

  assign accept = ap_rst_n & (occ_q != 2'd2);
  assign hs     = accept & gv;
  assign pop    = upd_req_tvalid & upd_req_tready;

  assign req_0_tready = hs & (gidx == 2'd0);
  assign req_1_tready = hs & (gidx == 2'd1);
  assign req_2_tready = hs & (gidx == 2'd2);
  assign req_3_tready = hs & (gidx == 2'd3);

  always_comb begin
    gdata = req_0_tdata;
    case (gidx)
      2'd1:    gdata = req_1_tdata;
      2'd2:    gdata = req_2_tdata;
      2'd3:    gdata = req_3_tdata;
      default: gdata = req_0_tdata;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!lo_pend || (hs && gidx[1])) begin
      starve_d = '0;
    end else if (hs && starve_q != LIM) begin
      starve_d = starve_q + 8'd1;
    end
  end

  assign occ_d = occ_q + {1'b0, hs} - {1'b0, pop};

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr_hi_q  <= 1'b0;
      rr_lo_q  <= 1'b0;
      starve_q <= '0;
      occ_q    <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      mem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      starve_q <= starve_d;
      if (hs) begin
        mem_q[wp_q] <= {gidx, gdata};
        wp_q        <= ~wp_q;
      end
      if (pop) begin
        rp_q <= ~rp_q;
      end
      if (hs && !gidx[1]) begin
        rr_hi_q <= ~gidx[0];
      end
      if (hs && gidx[1]) begin
        rr_lo_q <= ~gidx[0];
      end
      if (cnt_clear) begin
        cnt_q <= '0;
      end else if (hs) begin
        cnt_q[gidx] <= cnt_q[gidx] + 32'd1;
      end
    end
  end

  assign upd_req_tvalid = (occ_q != 2'd0);
  assign {upd_req_tuser, upd_req_tdata} = mem_q[rp_q];

  assign grant_count_0 = cnt_q[0];
  assign grant_count_1 = cnt_q[1];
  assign grant_count_2 = cnt_q[2];
  assign grant_count_3 = cnt_q[3];

endmodule

// File: tb/tb_ingr_upd_req_arb.sv
// Directed bench for ingr_upd_req_arb: single source, round-robin,
// starvation guard, backpressure, counter wrap/clear and mid-run reset.
module tb_ingr_upd_req_arb;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [63:0] req_0_tdata, req_1_tdata, req_2_tdata, req_3_tdata;
  logic        req_0_tvalid, req_1_tvalid, req_2_tvalid, req_3_tvalid;
  logic        req_0_tready, req_1_tready, req_2_tready, req_3_tready;
  logic [63:0] upd_req_tdata;
  logic [1:0]  upd_req_tuser;
  logic        upd_req_tvalid;
  logic        upd_req_tready;
  logic        cnt_clear;
  logic [31:0] grant_count_0, grant_count_1, grant_count_2, grant_count_3;
  logic [3:0]  rdy;

  int total = 0;
  int bad   = 0;

  ingr_upd_req_arb #(.DATA_WIDTH(64), .STARVE_LIMIT(8)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .req_0_tdata    (req_0_tdata),
    .req_0_tvalid   (req_0_tvalid),
    .req_0_tready   (req_0_tready),
    .req_1_tdata    (req_1_tdata),
    .req_1_tvalid   (req_1_tvalid),
    .req_1_tready   (req_1_tready),
    .req_2_tdata    (req_2_tdata),
    .req_2_tvalid   (req_2_tvalid),
    .req_2_tready   (req_2_tready),
    .req_3_tdata    (req_3_tdata),
    .req_3_tvalid   (req_3_tvalid),
    .req_3_tready   (req_3_tready),
    .upd_req_tdata  (upd_req_tdata),
    .upd_req_tuser  (upd_req_tuser),
    .upd_req_tvalid (upd_req_tvalid),
    .upd_req_tready (upd_req_tready),
    .cnt_clear      (cnt_clear),
    .grant_count_0  (grant_count_0),
    .grant_count_1  (grant_count_1),
    .grant_count_2  (grant_count_2),
    .grant_count_3  (grant_count_3)
  );

  always #5 ap_clk = ~ap_clk;

  assign rdy = {req_3_tready, req_2_tready, req_1_tready, req_0_tready};

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int seq [18] = '{0, 1, 0, 1, 0, 1, 0, 1, 3,
                   0, 1, 0, 1, 0, 1, 0, 1, 2};

  initial begin
    ap_rst_n       = 1'b0;
    req_0_tdata    = '0;
    req_1_tdata    = '0;
    req_2_tdata    = '0;
    req_3_tdata    = '0;
    req_0_tvalid   = 1'b0;
    req_1_tvalid   = 1'b0;
    req_2_tvalid   = 1'b0;
    req_3_tvalid   = 1'b0;
    upd_req_tready = 1'b0;
    cnt_clear      = 1'b0;
    tick();
    req_0_tvalid = 1'b1;
    #1;
    chk("rst_tready0", {63'd0, req_0_tready}, 64'd0);
    tick();
    ap_rst_n     = 1'b1;
    req_0_tvalid = 1'b0;
    #1;
    chk("rst_tvalid", {63'd0, upd_req_tvalid}, 64'd0);
    chk("rst_tdata", upd_req_tdata, 64'd0);
    chk("rst_tuser", {62'd0, upd_req_tuser}, 64'd0);
    chk("rst_cnt0", {32'd0, grant_count_0}, 64'd0);
    chk("rst_cnt3", {32'd0, grant_count_3}, 64'd0);

    // single source on port 2
    upd_req_tready = 1'b1;
    req_2_tvalid   = 1'b1;
    req_2_tdata    = 64'h11;
    #1;
    chk("ss_rdy", {60'd0, rdy}, 64'h4);
    chk("ss_tvalid0", {63'd0, upd_req_tvalid}, 64'd0);
    tick();
    req_2_tdata = 64'h22;
    #1;
    chk("ss_tvalid1", {63'd0, upd_req_tvalid}, 64'd1);
    chk("ss_data1", upd_req_tdata, 64'h11);
    chk("ss_user1", {62'd0, upd_req_tuser}, 64'd2);
    tick();
    req_2_tdata = 64'h33;
    #1;
    chk("ss_data2", upd_req_tdata, 64'h22);
    tick();
    req_2_tvalid = 1'b0;
    #1;
    chk("ss_data3", upd_req_tdata, 64'h33);
    chk("ss_tvalid3", {63'd0, upd_req_tvalid}, 64'd1);
    tick();
    chk("ss_drained", {63'd0, upd_req_tvalid}, 64'd0);
    chk("ss_cnt2", {32'd0, grant_count_2}, 64'd3);

    // high-group round robin
    req_0_tvalid = 1'b1;
    req_1_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy", {60'd0, rdy}, (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_starve", {56'd0, dut.starve_q}, 64'd0);
      tick();
    end
    req_0_tvalid = 1'b0;
    req_1_tvalid = 1'b0;
    tick();
    tick();
    tick();

    // starvation guard, all four valid
    req_0_tdata  = 64'hA0;
    req_1_tdata  = 64'hA1;
    req_2_tdata  = 64'hA2;
    req_3_tdata  = 64'hA3;
    req_0_tvalid = 1'b1;
    req_1_tvalid = 1'b1;
    req_2_tvalid = 1'b1;
    req_3_tvalid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk("sv_grant", {60'd0, rdy}, 64'(1) << seq[i]);
      if (i > 0) begin
        chk("sv_tuser", {62'd0, upd_req_tuser}, 64'(seq[i-1]));
        chk("sv_tdata", upd_req_tdata, 64'hA0 + 64'(seq[i-1]));
      end
      tick();
    end
    req_0_tvalid = 1'b0;
    req_1_tvalid = 1'b0;
    req_2_tvalid = 1'b0;
    req_3_tvalid = 1'b0;
    #1;
    chk("sv_last", {62'd0, upd_req_tuser}, 64'd2);
    tick();
    tick();
    chk("sv_cnt0", {32'd0, grant_count_0}, 64'd10);
    chk("sv_cnt1", {32'd0, grant_count_1}, 64'd10);
    chk("sv_cnt2", {32'd0, grant_count_2}, 64'd4);
    chk("sv_cnt3", {32'd0, grant_count_3}, 64'd1);

    // backpressure
    upd_req_tready = 1'b0;
    req_0_tvalid   = 1'b1;
    req_0_tdata    = 64'h100;
    #1;
    chk("bp_rdy1", {60'd0, rdy}, 64'h1);
    chk("bp_tvalid0", {63'd0, upd_req_tvalid}, 64'd0);
    tick();
    req_0_tdata = 64'h101;
    #1;
    chk("bp_rdy2", {60'd0, rdy}, 64'h1);
    chk("bp_head1", upd_req_tdata, 64'h100);
    tick();
    req_0_tdata = 64'h102;
    #1;
    chk("bp_full_rdy", {60'd0, rdy}, 64'h0);
    chk("bp_head2", upd_req_tdata, 64'h100);
    tick();
    upd_req_tready = 1'b1;
    #1;
    chk("bp_full_rdy2", {60'd0, rdy}, 64'h0);
    chk("bp_head3", upd_req_tdata, 64'h100);
    chk("bp_occ", {62'd0, dut.occ_q}, 64'd2);
    tick();
    #1;
    chk("bp_rdy_back", {60'd0, rdy}, 64'h1);
    chk("bp_pop2", upd_req_tdata, 64'h101);
    tick();
    req_0_tvalid = 1'b0;
    #1;
    chk("bp_pop3", upd_req_tdata, 64'h102);
    chk("bp_tvalid3", {63'd0, upd_req_tvalid}, 64'd1);
    tick();
    chk("bp_empty", {63'd0, upd_req_tvalid}, 64'd0);
    chk("bp_cnt0", {32'd0, grant_count_0}, 64'd13);

    // counter wrap and clear
    force dut.cnt_q = {4{32'hFFFF_FFFF}};
    #1;
    release dut.cnt_q;
    req_0_tvalid = 1'b1;
    #1;
    chk("wr_rdy", {60'd0, rdy}, 64'h1);
    tick();
    req_0_tvalid = 1'b0;
    req_1_tvalid = 1'b1;
    cnt_clear    = 1'b1;
    #1;
    chk("wr_cnt0", {32'd0, grant_count_0}, 64'd0);
    chk("wr_cnt1", {32'd0, grant_count_1}, 64'hFFFF_FFFF);
    chk("wr_cnt2", {32'd0, grant_count_2}, 64'hFFFF_FFFF);
    chk("clr_rdy", {60'd0, rdy}, 64'h2);
    tick();
    req_1_tvalid = 1'b0;
    cnt_clear    = 1'b0;
    #1;
    chk("clr_cnt1", {32'd0, grant_count_1}, 64'd0);
    chk("clr_cnt0", {32'd0, grant_count_0}, 64'd0);
    chk("clr_cnt3", {32'd0, grant_count_3}, 64'd0);
    tick();
    tick();

    // reset with a full buffer
    upd_req_tready = 1'b0;
    req_0_tvalid   = 1'b1;
    tick();
    tick();
    chk("mr_occ", {62'd0, dut.occ_q}, 64'd2);
    chk("mr_rr_hi", {63'd0, dut.rr_hi_q}, 64'd1);
    chk("mr_rr_lo", {63'd0, dut.rr_lo_q}, 64'd1);
    ap_rst_n = 1'b0;
    #1;
    chk("mr_rdy_rst", {60'd0, rdy}, 64'h0);
    tick();
    ap_rst_n       = 1'b1;
    req_0_tvalid   = 1'b0;
    upd_req_tready = 1'b1;
    #1;
    chk("mr_tvalid", {63'd0, upd_req_tvalid}, 64'd0);
    chk("mr_cnt0", {32'd0, grant_count_0}, 64'd0);
    chk("mr_rr_hi0", {63'd0, dut.rr_hi_q}, 64'd0);
    chk("mr_rr_lo0", {63'd0, dut.rr_lo_q}, 64'd0);
    chk("mr_occ0", {62'd0, dut.occ_q}, 64'd0);
    chk("mr_tdata", upd_req_tdata, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
